// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write arbiter.
package fifo_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_ID_W    = id_w(DEF_NUM_REQ);

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first set request strictly after last.
module rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = id_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic          found,
   output logic [IW-1:0] idx
);

   localparam logic [IW:0] NV = (IW+1)'(N);

   logic [N-1:0] rot;
   logic [IW:0]  base;
   logic [IW:0]  off;
   logic [IW:0]  sum;

   always_comb begin
      base = {1'b0, last} + (IW+1)'(1);
      // Rotating the doubled vector puts last+1 at bit 0.
      rot  = N'({req, req} >> base);
      off  = '0;
      for (int i = N-1; i >= 0; i--) begin
         if (rot[i]) off = (IW+1)'(i);
      end
      sum = base + off;
      if (sum >= NV) sum = sum - NV;
      found = |req;
      idx   = sum[IW-1:0];
   end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter driving the write port of one synchronous FIFO.
module fifo_wr_arb
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic                          fifo_full_i,
   input  logic                          fifo_almost_full_i,
   output logic                          fifo_wren_o,
   output logic [DATA_WIDTH-1:0]         fifo_wdata_o,
   output logic                          gnt_valid_o,
   output logic [id_w(NUM_REQ)-1:0]      gnt_id_o
);

   localparam int IW = id_w(NUM_REQ);
   localparam int CW = $clog2(BURST_LEN) + 1;

   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
   localparam logic [IW-1:0] LAST_RST  = IW'(NUM_REQ - 1);

   arb_state_t    state;
   arb_state_t    state_nxt;
   logic [IW-1:0] gnt_id;
   logic [IW-1:0] gnt_id_nxt;
   logic [IW-1:0] last_id;
   logic [IW-1:0] last_id_nxt;
   logic [IW-1:0] pick_id;
   logic [CW-1:0] beat_cnt;
   logic [CW-1:0] beat_cnt_nxt;
   logic          pick_found;
   logic          in_grant;
   logic          open;
   logic          beat;

   rr_picker #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req   (req_valid_i),
      .last  (last_id),
      .found (pick_found),
      .idx   (pick_id)
   );

   // Write gated on the live full flag and suppressed during reset.
   assign in_grant     = (state == ARB_GRANT);
   assign open         = in_grant & ~fifo_full_i & ~rst;
   assign beat         = open & req_valid_i[gnt_id];
   assign req_ready_o  = open ? (NUM_REQ'(1) << gnt_id) : '0;
   assign fifo_wren_o  = beat;
   assign fifo_wdata_o = req_data_i[gnt_id*DATA_WIDTH +: DATA_WIDTH];
   assign gnt_valid_o  = in_grant;
   assign gnt_id_o     = gnt_id;

   always_comb begin
      state_nxt    = state;
      gnt_id_nxt   = gnt_id;
      last_id_nxt  = last_id;
      beat_cnt_nxt = beat_cnt;
      unique case (state)
         ARB_IDLE: begin
            if (pick_found && !fifo_almost_full_i) begin
               state_nxt    = ARB_GRANT;
               gnt_id_nxt   = pick_id;
               last_id_nxt  = pick_id;
               beat_cnt_nxt = '0;
            end
         end
         ARB_GRANT: begin
            if (!req_valid_i[gnt_id]) begin
               state_nxt = ARB_IDLE;
            end else if (beat) begin
               if (beat_cnt == LAST_BEAT) state_nxt = ARB_IDLE;
               else beat_cnt_nxt = beat_cnt + CW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ARB_IDLE;
         gnt_id   <= '0;
         last_id  <= LAST_RST;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         gnt_id   <= gnt_id_nxt;
         last_id  <= last_id_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: bursts, rotation, stalls, throttle, reset.
module tb_fifo_wr_arb;

   localparam int NR = 4;
   localparam int DW = 32;

   logic           clk;
   logic           rst;
   logic [NR-1:0]  valid;
   logic [NR*DW-1:0] data;
   logic [NR-1:0]  ready;
   logic           full;
   logic           af;
   logic           wren;
   logic [DW-1:0]  wdata;
   logic           gv;
   logic [1:0]     gid;

   int n_chk;
   int n_fail;

   fifo_wr_arb #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .BURST_LEN  (4)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .req_valid_i        (valid),
      .req_data_i         (data),
      .req_ready_o        (ready),
      .fifo_full_i        (full),
      .fifo_almost_full_i (af),
      .fifo_wren_o        (wren),
      .fifo_wdata_o       (wdata),
      .gnt_valid_o        (gv),
      .gnt_id_o           (gid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_d(input int i, input logic [DW-1:0] v);
      data[i*DW +: DW] = v;
   endtask

   task automatic chk1(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk(input string tag, input logic [3:0] er,
                      input logic ew, input logic egv,
                      input logic [1:0] eid);
      chk1({tag, "_ready"}, 32'(ready), 32'(er));
      chk1({tag, "_wren"}, 32'(wren), 32'(ew));
      chk1({tag, "_gv"}, 32'(gv), 32'(egv));
      chk1({tag, "_gid"}, 32'(gid), 32'(eid));
      chk1({tag, "_nofullwr"}, 32'(wren & full), 32'd0);
      chk1({tag, "_onehot"}, 32'($onehot0(ready)), 32'd1);
   endtask

   task automatic chk_g(input string tag, input logic [1:0] id,
                        input logic ew);
      logic [3:0] er;
      er = 4'b0001 << id;
      chk(tag, er, ew, 1'b1, id);
   endtask

   task automatic chk_i(input string tag, input logic [1:0] id);
      chk(tag, 4'b0000, 1'b0, 1'b0, id);
   endtask

   task automatic chkd(input string tag, input logic [DW-1:0] e);
      chk1({tag, "_wdata"}, wdata, e);
   endtask

   initial begin
      int ord[5];
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b1;
      valid  = '0;
      data   = '0;
      full   = 1'b0;
      af     = 1'b0;
      set_d(0, 32'h0BAD_0000);
      set_d(1, 32'h0BAD_0001);
      step();
      step();
      settle();
      chk("reset", 4'b0000, 1'b0, 1'b0, 2'd0);
      chkd("reset", 32'h0BAD_0000);

      // Single requester: four beats, bubble, regrant, then drop.
      step();
      rst   = 1'b0;
      valid = 4'b0001;
      settle();
      chk_i("t1_idle", 2'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         set_d(0, 32'hD000_0000 + k);
         settle();
         chk_g("t1_beat", 2'd0, 1'b1);
         chkd("t1_beat", 32'hD000_0000 + k);
      end
      step();
      settle();
      chk_i("t1_bubble", 2'd0);
      step();
      valid = 4'b0000;
      settle();
      chk("t1_drop", 4'b0001, 1'b0, 1'b1, 2'd0);
      step();
      settle();
      chk_i("t1_rel", 2'd0);

      // All four requesting: rotation 0,1,2,3,0.
      step();
      rst   = 1'b1;
      valid = 4'b1111;
      for (int i = 0; i < NR; i++) set_d(i, 32'hA5A5_0000 + i);
      settle();
      chk("t2_rst", 4'b0000, 1'b0, 1'b0, 2'd0);
      step();
      rst = 1'b0;
      settle();
      chk_i("t2_idle", 2'd0);
      ord = '{0, 1, 2, 3, 0};
      for (int b = 0; b < 5; b++) begin
         for (int k = 0; k < 4; k++) begin
            step();
            settle();
            chk_g("t2_beat", 2'(ord[b]), 1'b1);
            chkd("t2_beat", 32'hA5A5_0000 + ord[b]);
         end
         step();
         settle();
         chk_i("t2_bubble", 2'(ord[b]));
      end

      // Early release of requester 2; next grant goes to 3.
      valid = 4'b1100;
      step();
      settle();
      chk_g("t3_b0", 2'd2, 1'b1);
      chkd("t3_b0", 32'hA5A5_0002);
      step();
      settle();
      chk_g("t3_b1", 2'd2, 1'b1);
      step();
      valid = 4'b1000;
      settle();
      chk("t3_drop", 4'b0100, 1'b0, 1'b1, 2'd2);
      step();
      settle();
      chk_i("t3_rel", 2'd2);
      for (int k = 0; k < 4; k++) begin
         step();
         settle();
         chk_g("t3_r3", 2'd3, 1'b1);
         chkd("t3_r3", 32'hA5A5_0003);
      end
      step();
      valid = 4'b0000;
      settle();
      chk_i("t3_end", 2'd3);

      // Full stall mid-burst on requester 1.
      valid = 4'b0010;
      set_d(1, 32'hE000_0000);
      step();
      settle();
      chk_g("t4_b0", 2'd1, 1'b1);
      chkd("t4_b0", 32'hE000_0000);
      step();
      set_d(1, 32'hE000_0001);
      settle();
      chk_g("t4_b1", 2'd1, 1'b1);
      chkd("t4_b1", 32'hE000_0001);
      step();
      set_d(1, 32'hE000_0002);
      full = 1'b1;
      settle();
      chk("t4_stall", 4'b0000, 1'b0, 1'b1, 2'd1);
      for (int k = 0; k < 2; k++) begin
         step();
         settle();
         chk("t4_stall", 4'b0000, 1'b0, 1'b1, 2'd1);
      end
      step();
      full = 1'b0;
      settle();
      chk_g("t4_b2", 2'd1, 1'b1);
      chkd("t4_b2", 32'hE000_0002);
      step();
      set_d(1, 32'hE000_0003);
      settle();
      chk_g("t4_b3", 2'd1, 1'b1);
      chkd("t4_b3", 32'hE000_0003);
      step();
      valid = 4'b0000;
      settle();
      chk_i("t4_end", 2'd1);

      // Almost-full throttle in IDLE, ignored mid-burst.
      valid = 4'b1111;
      af    = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         settle();
         chk_i("t5_hold", 2'd1);
      end
      step();
      af = 1'b0;
      settle();
      chk_i("t5_fall", 2'd1);
      step();
      settle();
      chk_g("t5_b0", 2'd2, 1'b1);
      af = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         settle();
         chk_g("t5_burst", 2'd2, 1'b1);
         chkd("t5_burst", 32'hA5A5_0002);
      end
      step();
      settle();
      chk_i("t5_idle", 2'd2);
      step();
      settle();
      chk_i("t5_idle2", 2'd2);
      af = 1'b0;

      // Reset at beat 2 of requester 3.
      step();
      settle();
      chk_g("t6_b0", 2'd3, 1'b1);
      step();
      settle();
      chk_g("t6_b1", 2'd3, 1'b1);
      step();
      rst = 1'b1;
      settle();
      chk1("t6_rst_wren", 32'(wren), 32'd0);
      chk1("t6_rst_gv", 32'(gv), 32'd1);
      chk1("t6_rst_gid", 32'(gid), 32'd3);
      step();
      rst = 1'b0;
      settle();
      chk("t6_after", 4'b0000, 1'b0, 1'b0, 2'd0);
      chkd("t6_after", 32'hA5A5_0000);
      step();
      settle();
      chk_g("t6_regrant", 2'd0, 1'b1);
      chkd("t6_regrant", 32'hA5A5_0000);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
